// File: rtl/vram_draw_controller.sv
// VRAM write-port owner: full-frame clear after reset or on request, then
// single-cycle pixel writes from the touch path with (x,y) to linear address mapping.
module vram_draw_controller #(
    parameter int                DISPLAY_WIDTH  = 240,
    parameter int                DISPLAY_HEIGHT = 320,
    parameter int                VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int                VRAM_W         = 16,
    parameter int                COORD_W        = 9,
    parameter logic [VRAM_W-1:0] CLEAR_COLOR    = '0,
    localparam int               AW             = $clog2(VRAM_L)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    input  logic               draw_valid,
    output logic               draw_ready,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [VRAM_W-1:0]  draw_color,
    output logic               vram_wr_ena,
    output logic [AW-1:0]      vram_wr_addr,
    output logic [VRAM_W-1:0]  vram_wr_data,
    output logic               busy,
    output logic               clear_done,
    output logic               draw_oob
);

    // state      | meaning
    // S_CLEARING | writing CLEAR_COLOR to every address, draws blocked
    // S_ACTIVE   | accepting draw requests, one write per accept
    typedef enum logic {S_CLEARING, S_ACTIVE} state_t;

    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(DISPLAY_WIDTH);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(DISPLAY_HEIGHT);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(VRAM_L - 1);
    localparam logic [AW-1:0]      ROW_PITCH = AW'(DISPLAY_WIDTH);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic          clear_last;
    logic          accept;
    logic          in_range;
    logic [AW-1:0] draw_addr;

    assign draw_ready = (state == S_ACTIVE) && !clear_req;
    assign busy       = (state == S_CLEARING);
    assign accept     = draw_valid && draw_ready;
    assign in_range   = (draw_x < X_LIM) && (draw_y < Y_LIM);
    // Truncation to AW bits is safe once the bounds check has passed.
    assign draw_addr  = AW'(draw_y) * ROW_PITCH + AW'(draw_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEARING;
            clr_cnt      <= '0;
            clear_last   <= 1'b0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= CLEAR_COLOR;
            clear_done   <= 1'b0;
            draw_oob     <= 1'b0;
        end else begin
            vram_wr_ena <= 1'b0;
            draw_oob    <= 1'b0;
            clear_done  <= clear_last;
            clear_last  <= 1'b0;
            case (state)
                S_CLEARING: begin
                    vram_wr_ena  <= 1'b1;
                    vram_wr_addr <= clr_cnt;
                    vram_wr_data <= CLEAR_COLOR;
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= S_ACTIVE;
                        clr_cnt    <= '0;
                        clear_last <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (clear_req) begin
                        state   <= S_CLEARING;
                        clr_cnt <= '0;
                    end else if (accept) begin
                        if (in_range) begin
                            vram_wr_ena  <= 1'b1;
                            vram_wr_addr <= draw_addr;
                            vram_wr_data <= draw_color;
                        end else begin
                            draw_oob <= 1'b1;
                        end
                    end
                end
                default: state <= S_CLEARING;
            endcase
        end
    end

endmodule

// File: doc/vram_draw_controller.md
Name: vram_draw_controller

Overview:
- Owns the VRAM write port. After reset or on request, it sequences a full-frame clear, writing CLEAR_COLOR to every address.
- Once the clear completes, it accepts pixel-draw requests from the touch path over a valid/ready handshake and converts (x,y) to a linear VRAM address.
- Sits between the ft6206 touch pipeline and the block_ram write port; the display controller keeps the read port.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row (x range).
- DISPLAY_HEIGHT, 320, rows (y range).
- VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, number of VRAM words.
- VRAM_W, 16, VRAM word width (ILI9341 RGB565).
- COORD_W, 9, width of x/y coordinate inputs.
- CLEAR_COLOR, 16'h0000, color written during clear (BLACK).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- clear_req  input  1  one-cycle (or level) request to re-clear the frame.
- draw_valid  input  1  draw request valid.
- draw_ready  output  1  controller can accept a draw this cycle.
- draw_x  input  COORD_W  pixel column.
- draw_y  input  COORD_W  pixel row.
- draw_color  input  VRAM_W  pixel color.
- vram_wr_ena  output  1  VRAM write enable.
- vram_wr_addr  output  $clog2(VRAM_L)  VRAM write address.
- vram_wr_data  output  VRAM_W  VRAM write data.
- busy  output  1  high while clearing.
- clear_done  output  1  one-cycle pulse when a clear finishes.
- draw_oob  output  1  one-cycle pulse when an accepted draw is out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (cycle rst is sampled high): state=S_CLEARING, clear counter=0, vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=CLEAR_COLOR, clear_done=0, draw_oob=0, busy=1. draw_ready=0 while busy.
- States: S_CLEARING and S_ACTIVE. busy = (state==S_CLEARING).
- All VRAM outputs, clear_done and draw_oob are registered.
- draw_ready is combinational: (state==S_ACTIVE) && !clear_req.
- S_CLEARING, per cycle:
  - Register vram_wr_ena=1, vram_wr_addr=counter, vram_wr_data=CLEAR_COLOR, then counter++.
  - The first clear write appears the cycle after rst deasserts.
  - Addresses 0..VRAM_L-1 are each written exactly once, in order, over VRAM_L consecutive cycles.
  - After issuing address VRAM_L-1: state goes to S_ACTIVE and counter to 0. clear_done=1 in the cycle after the last write is presented, together with vram_wr_ena=0.
  - The counter never presents address VRAM_L (no off-by-one write).
- clear_req while in S_CLEARING is ignored; the clear continues without restarting.
- rst mid-clear restarts the clear from address 0.
- S_ACTIVE, on accept (draw_valid && draw_ready):
  - If draw_x<DISPLAY_WIDTH and draw_y<DISPLAY_HEIGHT: next cycle vram_wr_ena=1, vram_wr_addr=draw_y*DISPLAY_WIDTH+draw_x, vram_wr_data=draw_color. Latency is 1 cycle.
  - Otherwise: no write, and draw_oob=1 for 1 cycle.
  - Inputs are sampled only on accept.
  - Back-to-back draws are accepted every cycle (throughput 1/cycle).
  - In cycles with no accept, vram_wr_ena=0.
- Address arithmetic: unsigned, computed in $clog2(VRAM_L) bits. The product is within range by construction after the bounds check.
- clear_req in S_ACTIVE:
  - draw_ready drops that cycle, so no draw is accepted.
  - Next cycle state=S_CLEARING with counter=0.
  - The first clear write (address 0) is presented one cycle later.
  - A draw accepted in the previous cycle still completes its write before the clear writes begin.
- rst has priority over clear_req and draw_valid in the same cycle.
- vram_wr_data holds its last value when vram_wr_ena=0. The bench must not check vram_wr_data in those cycles.

Test Plan:
- Power-up clear, default params: hold rst 2 cycles, release -> VRAM_L=76800 consecutive writes of 16'h0000 to addresses 0..76799; busy=1 throughout; clear_done pulses once in cycle 76801; draw_ready=1 afterwards.
- Draw mapping: after clear, draw (x=239,y=319,color=16'hF800) -> one cycle later wr_ena=1, addr=76799, data=F800. Draw (x=0,y=1) -> addr=240.
- Out of range: draw (x=240,y=0), then (x=0,y=320) -> no writes; draw_oob pulses once per request; draw_ready stays 1.
- Streaming: 4 draws on consecutive cycles with valid held high -> 4 writes on consecutive cycles, in order, with correct addresses and colors.
- clear_req while drawing: accept a draw at cycle N, assert clear_req at N+1 with draw_valid high -> draw N written at N+1; draw_ready=0 at N+1; busy=1 from N+2; address 0 cleared at N+3; the full clear completes.
- Reset mid-clear, params WIDTH=4, HEIGHT=3: assert rst at clear address 5, release -> clear restarts at 0, writes 0..11, clear_done once. clear_req during clearing -> no restart, exactly 12 writes.
